fill_port_arbiter: RTL and testbench

Shares the single main-memory fill port between NUM_REQ line caches (texture, depth, colour tiles) in the pixel pipeline. Requesters present a line address. The arbiter picks one with round-robin, drives the memory read request, and steers the memory's write-burst stream back to the granted cache only. It then releases the port on burst completion. It also keeps per-fill statistics for bring-up.

---
 rtl/fill_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_fill_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fill_port_arbiter.sv
// fill_port_arbiter: shares the single main-memory fill port between NUM_REQ
// line caches. Round-robin picks one requester, issues its line read, steers
// the returning write burst to that cache only, and frees the port when the
// burst completes. Also keeps fill statistics for bring-up.
//
// Handshake on the burst stream: mem_wr_en is "valid", mem_wr_ack is "ready";
// a beat transfers on a cycle where both are high in XFER. mem_wr_ack is the
// owner's req_ack, so a cache that cannot accept stalls the memory indefinitely.
module fill_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 19,
  parameter int DW      = 32,
  parameter int CNTW    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    fill_done,
  output logic [AW-1:0]         cache_wr_addr,
  output logic [DW-1:0]         cache_wr_data,
  output logic [NUM_REQ-1:0]    cache_wr_en,
  output logic [AW-1:0]         mem_rd_addr,
  output logic                  mem_rd_en,
  input  logic [AW-1:0]         mem_wr_addr,
  input  logic [DW-1:0]         mem_wr_data,
  input  logic                  mem_wr_en,
  input  logic                  mem_wr_done,
  output logic                  mem_wr_ack,
  output logic                  busy,
  output logic [CNTW-1:0]       fill_count,
  output logic [CNTW-1:0]       last_fill_words
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   owner_inc;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            win_found;
  int              cand;
  logic            in_xfer;
  logic            beat_acc;
  logic [CNTW-1:0] beat_cnt;
  logic [CNTW-1:0] beat_next;

  assign in_xfer = (state == XFER);
  assign busy    = (state != IDLE);

  // Burst steering: data/address broadcast, enable and ack gated by ownership.
  assign cache_wr_addr = mem_wr_addr;
  assign cache_wr_data = mem_wr_data;
  assign cache_wr_en   = {NUM_REQ{mem_wr_en & in_xfer}} & grant;
  assign mem_wr_ack    = in_xfer & (|(req_ack & grant));

  // Accepted-beat count including the current cycle, saturating at all ones.
  assign beat_acc  = in_xfer & mem_wr_en & mem_wr_ack;
  assign beat_next = (beat_acc && (beat_cnt != {CNTW{1'b1}})) ? beat_cnt + CNTW'(1) : beat_cnt;

  // Pointer that follows the completing owner, so it becomes lowest priority.
  assign owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

  // Round-robin search: first set req bit at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(rr_ptr) + k) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: RELEASE always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = XFER;
      XFER:    if (mem_wr_done) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, memory read request, fill pulse, pointer and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant           <= '0;
      owner           <= '0;
      rr_ptr          <= '0;
      mem_rd_addr     <= '0;
      mem_rd_en       <= 1'b0;
      fill_done       <= '0;
      beat_cnt        <= '0;
      fill_count      <= '0;
      last_fill_words <= '0;
    end else begin
      fill_done <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant       <= ONE_HOT0 << win_idx;
            owner       <= win_idx;
            mem_rd_addr <= req_addr[win_idx*AW +: AW];
            mem_rd_en   <= 1'b1;
            beat_cnt    <= '0;
          end
        end
        XFER: begin
          beat_cnt <= beat_next;
          if (mem_wr_done) begin
            mem_rd_en       <= 1'b0;
            grant           <= '0;
            fill_done       <= ONE_HOT0 << owner;
            rr_ptr          <= owner_inc;
            fill_count      <= fill_count + CNTW'(1);
            last_fill_words <= beat_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_port_arbiter.sv
// Directed bench for fill_port_arbiter: a small memory-burst emulator task
// plus hand-computed expectations for grant order, steering and statistics.
module tb_fill_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 19;
  localparam int DW      = 32;
  localparam int CNTW    = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    fill_done;
  logic [AW-1:0]         cache_wr_addr;
  logic [DW-1:0]         cache_wr_data;
  logic [NUM_REQ-1:0]    cache_wr_en;
  logic [AW-1:0]         mem_rd_addr;
  logic                  mem_rd_en;
  logic [AW-1:0]         mem_wr_addr;
  logic [DW-1:0]         mem_wr_data;
  logic                  mem_wr_en;
  logic                  mem_wr_done;
  logic                  mem_wr_ack;
  logic                  busy;
  logic [CNTW-1:0]       fill_count;
  logic [CNTW-1:0]       last_fill_words;

  int checks = 0;
  int errors = 0;

  fill_port_arbiter #(
    .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_ack(req_ack),
    .grant(grant), .fill_done(fill_done), .cache_wr_addr(cache_wr_addr),
    .cache_wr_data(cache_wr_data), .cache_wr_en(cache_wr_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .mem_wr_done(mem_wr_done),
    .mem_wr_ack(mem_wr_ack), .busy(busy), .fill_count(fill_count),
    .last_fill_words(last_fill_words)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory burst emulator. Starts in the first XFER cycle; returns just after
  // the done edge (or after the last beat edge when send_done is 0).
  task automatic burst(input int n, input int owner, input int stall_at, input int stall_len,
                       input bit isolate, input bit send_done, input logic [AW-1:0] exp_rd);
    int acc = 0;
    int stalled = 0;
    int guard = 0;
    logic exp_ack;
    logic [NUM_REQ-1:0] exp_grant;
    exp_grant = '0;
    exp_grant[owner] = 1'b1;
    while (acc < n && guard < n + stall_len + 50) begin
      guard++;
      mem_wr_en   = 1'b1;
      mem_wr_done = 1'b0;
      mem_wr_addr = AW'(acc);
      mem_wr_data = 32'hD000_0000 + DW'(acc);
      if (acc == stall_at && stalled < stall_len) begin
        req_ack[owner] = 1'b0;
        stalled++;
      end else begin
        req_ack[owner] = 1'b1;
      end
      if (isolate) begin
        req_ack[1-owner] = guard[0];
        req_addr[(1-owner)*AW +: AW] = AW'(guard * 3);
        req_addr[owner*AW +: AW]     = AW'(guard * 7);
      end
      exp_ack = req_ack[owner];
      #1;
      check("mem_wr_ack", mem_wr_ack, exp_ack);
      check("cache_wr_en", cache_wr_en, exp_grant);
      check("cache_wr_data", cache_wr_data, mem_wr_data);
      check("mem_rd_addr_held", mem_rd_addr, exp_rd);
      check("mem_rd_en_held", mem_rd_en, 1'b1);
      check("grant_held", grant, exp_grant);
      if (exp_ack) acc++;
      if (send_done && acc == n) mem_wr_done = 1'b1;
      step();
    end
    if (acc < n) check("burst_timeout", acc, n);
    mem_wr_en   = 1'b0;
    mem_wr_done = 1'b0;
  endtask

  // Checks in the RELEASE cycle and the IDLE cycle after it.
  task automatic check_done(input int owner, input int exp_count, input int exp_words,
                            input logic [NUM_REQ-1:0] req_after);
    logic [NUM_REQ-1:0] exp_fd;
    exp_fd = '0;
    exp_fd[owner] = 1'b1;
    check("fill_done_pulse", fill_done, exp_fd);
    check("grant_released", grant, '0);
    check("mem_rd_en_low", mem_rd_en, 1'b0);
    check("busy_release", busy, 1'b1);
    check("fill_count", fill_count, exp_count);
    check("last_fill_words", last_fill_words, exp_words);
    req = req_after;
    step();
    check("fill_done_cleared", fill_done, '0);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_ack = 2'b11;
    mem_wr_addr = '0; mem_wr_data = '0; mem_wr_en = 1'b0; mem_wr_done = 1'b0;
    step(); step();
    check("rst_grant", grant, '0);
    check("rst_fill_done", fill_done, '0);
    check("rst_mem_rd_en", mem_rd_en, 1'b0);
    check("rst_mem_rd_addr", mem_rd_addr, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_fill_count", fill_count, '0);
    check("rst_last_words", last_fill_words, '0);
    rst = 1'b0;

    // Single 512-word fill for requester 0
    req_addr[0*AW +: AW] = 19'h00100;
    req = 2'b01;
    step();
    check("t1_grant", grant, 2'b01);
    check("t1_rd_en", mem_rd_en, 1'b1);
    check("t1_rd_addr", mem_rd_addr, 19'h00100);
    check("t1_busy", busy, 1'b1);
    burst(512, 0, -1, 0, 1'b0, 1'b1, 19'h00100);
    check_done(0, 1, 512, 2'b00);

    // Spurious done while idle
    mem_wr_done = 1'b1;
    step();
    mem_wr_done = 1'b0;
    check("spur_busy", busy, 1'b0);
    check("spur_count", fill_count, 16'd1);
    check("spur_fill_done", fill_done, '0);
    check("spur_grant", grant, '0);
    step();
    check("spur_busy2", busy, 1'b0);

    // Reset so rr_ptr=0, then contention with req=11 held: 01,10,01,10
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_count", fill_count, '0);
    req_addr[0*AW +: AW] = 19'h00200;
    req_addr[1*AW +: AW] = 19'h00300;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_grant", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      burst(8, i % 2, -1, 0, 1'b0, 1'b1, (i % 2 == 0) ? 19'h00200 : 19'h00300);
      check_done(i % 2, i + 1, 8, (i == 3) ? 2'b00 : 2'b11);
    end

    // Owner stall: 20 cycles of req_ack[0]=0 after 10 beats
    req_addr[0*AW +: AW] = 19'h00400;
    req = 2'b01;
    step();
    check("stall_grant", grant, 2'b01);
    burst(64, 0, 10, 20, 1'b0, 1'b1, 19'h00400);
    check_done(0, 5, 64, 2'b00);

    // Isolation: requester 1 toggles ack and both addresses change mid-burst
    req_addr[0*AW +: AW] = 19'h00500;
    req = 2'b01;
    step();
    check("iso_grant", grant, 2'b01);
    burst(32, 0, -1, 0, 1'b1, 1'b1, 19'h00500);
    check_done(0, 6, 32, 2'b00);
    req_ack = 2'b11;

    // Reset mid-burst at beat 100
    req_addr[0*AW +: AW] = 19'h00600;
    req = 2'b01;
    step();
    check("mid_grant", grant, 2'b01);
    burst(100, 0, -1, 0, 1'b0, 1'b0, 19'h00600);
    rst = 1'b1;
    mem_wr_en = 1'b1;
    req = 2'b00;
    step();
    check("mid_rst_grant", grant, '0);
    check("mid_rst_fill_done", fill_done, '0);
    check("mid_rst_rd_en", mem_rd_en, 1'b0);
    check("mid_rst_rd_addr", mem_rd_addr, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_count", fill_count, '0);
    check("mid_rst_words", last_fill_words, '0);
    check("mid_rst_cache_en", cache_wr_en, '0);
    check("mid_rst_wr_ack", mem_wr_ack, 1'b0);
    rst = 1'b0;
    mem_wr_en = 1'b0;
    req_addr[1*AW +: AW] = 19'h00700;
    req = 2'b10;
    step();
    check("post_rst_fill_done", fill_done, '0);
    check("post_rst_grant", grant, 2'b10);
    check("post_rst_rd_addr", mem_rd_addr, 19'h00700);
    burst(4, 1, -1, 0, 1'b0, 1'b1, 19'h00700);
    check_done(1, 1, 4, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
